// File: rtl/tensor_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tensor_instruction_sequencer
//
// Front-end scheduler between the host instruction stream and the tensor-core
// cpu. Host words are buffered in a FIFO and issued at most one per cycle on
// the cpu instruction bus. NOPs are inserted while burst transfers and
// operate instructions are in flight, because the cpu does no interlocking.
// Bytes returned by generic reads and burst reads are collected into a result
// byte stream.
//
// Ports
//   clock_in                   single clock, rising edge
//   reset_in                   asynchronous active-high reset
//   flush_in                   synchronous abort: empty FIFO, issue cpu reset
//   host_instruction_valid_in  host word valid
//   host_instruction_in        host instruction or burst data word
//   host_instruction_ready_out FIFO can accept a word this cycle
//   cpu_instruction_out        registered cpu instruction (NOP when idle)
//   cpu_output_in              cpu read data
//   result_valid_out           one result byte this cycle (no backpressure)
//   result_data_out            result byte
//   busy_out                   FSM not idle or FIFO not empty
//   fifo_count_out             FIFO occupancy
//   state_out                  debug view of the FSM state
//
// Handshake: a host word is transferred on a rising edge where
// host_instruction_valid_in and host_instruction_ready_out are both high and
// flush_in is low; ready depends only on the registered FIFO count.
// -----------------------------------------------------------------------------
module tensor_instruction_sequencer #(
  parameter int FIFO_DEPTH      = 8,
  parameter int OPERATE_LATENCY = 5
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        flush_in,
  input  logic                        host_instruction_valid_in,
  input  logic [15:0]                 host_instruction_in,
  output logic                        host_instruction_ready_out,
  output logic [15:0]                 cpu_instruction_out,
  input  logic [7:0]                  cpu_output_in,
  output logic                        result_valid_out,
  output logic [7:0]                  result_data_out,
  output logic                        busy_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
  output logic [2:0]                  state_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (OPERATE_LATENCY > 9) ? $clog2(OPERATE_LATENCY + 1) : 4;

  localparam logic [15:0] NOP_INSTR   = 16'h0000;
  localparam logic [15:0] RESET_INSTR = 16'h000C;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BW_DATA  = 3'd1,
    S_BR_DRAIN = 3'd2,
    S_OP_WAIT  = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic              capture_pending;

  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic [15:0]       head;
  logic              head_is_burst_write;
  logic              push;
  logic              pop;

  assign head                = fifo_mem[rd_ptr];
  assign head_is_burst_write = (head[1:0] == 2'b11) && head[2];

  assign host_instruction_ready_out = (count != CW'(FIFO_DEPTH));
  assign fifo_count_out             = count;
  assign busy_out                   = (state != S_IDLE) || (count != '0);
  assign state_out                  = state;

  // A push during flush is dropped; there is no bypass from input to output.
  assign push = host_instruction_valid_in && host_instruction_ready_out && !flush_in;

  // Pop decision. A burst write header waits until all 5 data words are
  // queued behind it so the data phase can stream without gaps.
  always_comb begin
    pop = 1'b0;
    if (!flush_in) begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            pop = head_is_burst_write ? (count >= CW'(6)) : 1'b1;
          end
        end
        S_BW_DATA: pop = 1'b1;
        default:   pop = 1'b0;
      endcase
    end
  end

  // FIFO storage carries no reset; only pointers and count do.
  always_ff @(posedge clock_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= host_instruction_in;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM. capture_pending schedules a sample of cpu_output_in on the
  // following edge: a generic read sets it once, and every BR_DRAIN cycle sets
  // it, which places the 9 burst samples one edge after each drain edge.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      cpu_instruction_out <= NOP_INSTR;
      capture_pending     <= 1'b0;
      result_valid_out    <= 1'b0;
      result_data_out     <= 8'h00;
    end else begin
      cpu_instruction_out <= NOP_INSTR;
      capture_pending     <= 1'b0;
      result_valid_out    <= capture_pending && !flush_in;
      if (capture_pending && !flush_in) begin
        result_data_out <= cpu_output_in;
      end

      if (flush_in) begin
        state               <= S_FLUSH;
        cnt                 <= '0;
        cpu_instruction_out <= RESET_INSTR;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              cpu_instruction_out <= head;
              case (head[1:0])
                2'b11: begin
                  if (head[2]) begin
                    state <= S_BW_DATA;
                    cnt   <= CNTW'(5);
                  end else begin
                    state <= S_BR_DRAIN;
                    cnt   <= CNTW'(9);
                  end
                end
                2'b10: begin
                  state <= S_OP_WAIT;
                  cnt   <= CNTW'(OPERATE_LATENCY);
                end
                2'b00: begin
                  if (head[3:2] == 2'b10) capture_pending <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_BW_DATA: begin
            // Raw data words: issued without decode.
            cpu_instruction_out <= head;
            cnt                 <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state <= S_IDLE;
          end
          S_BR_DRAIN: begin
            capture_pending <= 1'b1;
            cnt             <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state <= S_IDLE;
          end
          S_OP_WAIT: begin
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state <= S_IDLE;
          end
          S_FLUSH: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
